// File: rtl/lcd_byte_writer.sv
// lcd_byte_writer: sends one byte to an HD44780-style LCD as two 4-bit nibbles, then waits out the controller's busy time
//   Clock                   in   system clock, all state changes on the rising edge
//   Reset                   in   asynchronous, active-low reset
//   iData[7:0]              in   byte to send
//   iRS                     in   0 = command, 1 = character data
//   iValid                  in   byte offered; taken when oReady is also high
//   oReady                  out  high only while idle
//   oDone                   out  one-cycle pulse once a byte's write and wait have completed
//   oLCD_Data[3:0]          out  DB7..DB4
//   oLCD_Enabled            out  E strobe, registered
//   oLCD_RegisterSelect     out  RS pin
//   oLCD_ReadWrite          out  tied 0, write only
//   oLCD_StrataFlashControl out  tied 1, keeps the shared-bus flash disabled
module lcd_byte_writer #(
    parameter int T_SETUP     = 2,
    parameter int T_EN        = 12,
    parameter int T_HOLD      = 1,
    parameter int T_GAP       = 50,
    parameter int T_WAIT      = 2000,
    parameter int T_WAIT_LONG = 82000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] iData,
    input  logic       iRS,
    input  logic       iValid,
    output logic       oReady,
    output logic       oDone,
    output logic [3:0] oLCD_Data,
    output logic       oLCD_Enabled,
    output logic       oLCD_RegisterSelect,
    output logic       oLCD_ReadWrite,
    output logic       oLCD_StrataFlashControl
);

    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_LEN = maxOf(maxOf(maxOf(T_SETUP, T_EN), maxOf(T_HOLD, T_GAP)),
                                   maxOf(T_WAIT, T_WAIT_LONG));
    // Wide enough for the longest phase so the counter can never wrap
    localparam int CW = maxOf(17, $clog2(MAX_LEN + 1));

    // A zero-length phase still occupies one cycle
    function automatic logic [CW-1:0] loadOf(input int len);
        return (len < 1) ? '0 : CW'(len - 1);
    endfunction

    localparam logic [CW-1:0] LD_SETUP     = loadOf(T_SETUP);
    localparam logic [CW-1:0] LD_EN        = loadOf(T_EN);
    localparam logic [CW-1:0] LD_HOLD      = loadOf(T_HOLD);
    localparam logic [CW-1:0] LD_GAP       = loadOf(T_GAP);
    localparam logic [CW-1:0] LD_WAIT      = loadOf(T_WAIT);
    localparam logic [CW-1:0] LD_WAIT_LONG = loadOf(T_WAIT_LONG);

    typedef enum logic [3:0] {
        IDLE,
        SETUP_HI,
        PULSE_HI,
        HOLD_HI,
        GAP,
        SETUP_LO,
        PULSE_LO,
        HOLD_LO,
        WAIT
    } stateT;

    stateT         state;
    stateT         nextState;
    logic [CW-1:0] count;
    logic [CW-1:0] nextCount;
    logic [CW-1:0] loadValue;
    logic [7:0]    byteReg;
    logic [7:0]    nextByte;
    logic          rsReg;
    logic          nextRs;
    logic [3:0]    nextData;
    logic          nextEnabled;
    logic          nextRsOut;
    logic          nextDone;
    logic          accept;
    logic          phaseDone;
    logic          isClearHome;

    assign accept      = (state == IDLE) && iValid;
    assign phaseDone   = (count == '0);
    // Clear display / return home need the long busy time
    assign isClearHome = !rsReg && (byteReg inside {8'h01, 8'h02, 8'h03});

    assign oReady                  = (state == IDLE);
    assign oLCD_ReadWrite          = 1'b0;
    assign oLCD_StrataFlashControl = 1'b1;

    // State register: every output except the constants and oReady is registered
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state               <= IDLE;
            count               <= '0;
            byteReg             <= '0;
            rsReg               <= 1'b0;
            oLCD_Data           <= '0;
            oLCD_Enabled        <= 1'b0;
            oLCD_RegisterSelect <= 1'b0;
            oDone               <= 1'b0;
        end else begin
            state               <= nextState;
            count               <= nextCount;
            byteReg             <= nextByte;
            rsReg               <= nextRs;
            oLCD_Data           <= nextData;
            oLCD_Enabled        <= nextEnabled;
            oLCD_RegisterSelect <= nextRsOut;
            oDone               <= nextDone;
        end
    end

    // Next state, phase counter and byte latch
    always_comb begin
        nextState = state;
        case (state)
            IDLE:     if (iValid)    nextState = SETUP_HI;
            SETUP_HI: if (phaseDone) nextState = PULSE_HI;
            PULSE_HI: if (phaseDone) nextState = HOLD_HI;
            HOLD_HI:  if (phaseDone) nextState = GAP;
            GAP:      if (phaseDone) nextState = SETUP_LO;
            SETUP_LO: if (phaseDone) nextState = PULSE_LO;
            PULSE_LO: if (phaseDone) nextState = HOLD_LO;
            HOLD_LO:  if (phaseDone) nextState = WAIT;
            WAIT:     if (phaseDone) nextState = IDLE;
            default:  nextState = IDLE;
        endcase
        loadValue = (nextState inside {SETUP_HI, SETUP_LO}) ? LD_SETUP :
                    (nextState inside {PULSE_HI, PULSE_LO}) ? LD_EN :
                    (nextState inside {HOLD_HI, HOLD_LO})   ? LD_HOLD :
                    (nextState == GAP)                      ? LD_GAP :
                    (nextState == WAIT)                     ? (isClearHome ? LD_WAIT_LONG : LD_WAIT) :
                                                              '0;
        // Every transition goes to a different state, so a change means "entering"
        nextCount = (nextState != state) ? loadValue : (phaseDone ? '0 : count - 1'b1);
        nextByte  = accept ? iData : byteReg;
        nextRs    = accept ? iRS : rsReg;
    end

    // Output values for the coming cycle, derived from the state being entered
    always_comb begin
        nextEnabled = nextState inside {PULSE_HI, PULSE_LO};
        nextData    = (nextState == IDLE) ? oLCD_Data :
                      (nextState inside {SETUP_HI, PULSE_HI, HOLD_HI, GAP}) ? nextByte[7:4] : nextByte[3:0];
        nextRsOut   = (nextState == IDLE) ? oLCD_RegisterSelect : nextRs;
        nextDone    = (state == WAIT) && phaseDone;
    end

endmodule

// File: doc/lcd_byte_writer.md
LCD_BYTE_WRITER -- requirements
Module: lcd_byte_writer

Interface
REQ-001 Parameter T_SETUP, 2: cycles that RS/data are stable before E rises (>=40 ns at 50 MHz).
REQ-002 Parameter T_EN, 12: cycles E is held high per nibble (>=230 ns).
REQ-003 Parameter T_HOLD, 1: cycles that data is held after E falls.
REQ-004 Parameter T_GAP, 50: idle cycles between the upper and lower nibble (1 us).
REQ-005 Parameter T_WAIT, 2000: post-byte wait cycles for normal bytes (40 us).
REQ-006 Parameter T_WAIT_LONG, 82000: post-byte wait cycles for clear/home commands (1.64 ms).
REQ-007 Clock  in  1  system clock; all state changes on the rising edge.
REQ-008 Reset  in  1  asynchronous, active-low reset.
REQ-009 iData  in  8  byte to send to the LCD.
REQ-010 iRS  in  1  register select for the byte: 0 = command, 1 = character data.
REQ-011 iValid  in  1  a byte is offered on iData/iRS.
REQ-012 oReady  out  1  the block can accept a byte this cycle.
REQ-013 oDone  out  1  one-cycle pulse when a byte's full write and wait have finished.
REQ-014 oLCD_Data  out  4  LCD data nibble, DB7..DB4.
REQ-015 oLCD_Enabled  out  1  LCD E strobe.
REQ-016 oLCD_RegisterSelect  out  1  LCD RS pin.
REQ-017 oLCD_ReadWrite  out  1  LCD R/W pin, constantly 0 (write only).
REQ-018 oLCD_StrataFlashControl  out  1  constantly 1, which keeps the shared-bus flash disabled.

Function
REQ-019 The block SHALL implement the states IDLE, SETUP_HI, PULSE_HI, HOLD_HI, GAP, SETUP_LO, PULSE_LO, HOLD_LO and WAIT.
REQ-020 oReady SHALL be 1 only in IDLE.
REQ-021 A byte SHALL be accepted on the rising edge where iValid=1 and oReady=1; iData and iRS SHALL be latched and the state SHALL go to SETUP_HI.
REQ-022 iValid SHALL be ignored outside IDLE; the block has no queue and never drops or corrupts the latched byte.
REQ-023 SETUP_HI, PULSE_HI and HOLD_HI SHALL last T_SETUP, T_EN and T_HOLD cycles respectively, with oLCD_Data = latched byte[7:4].
REQ-024 GAP SHALL last T_GAP cycles, with E=0 and oLCD_Data holding the upper nibble.
REQ-025 SETUP_LO, PULSE_LO and HOLD_LO SHALL mirror the upper-nibble phases with oLCD_Data = latched byte[3:0].
REQ-026 oLCD_Enabled SHALL be 1 only in PULSE_HI and PULSE_LO, and SHALL be driven from a register so it is glitch-free.
REQ-027 oLCD_RegisterSelect SHALL equal the latched iRS from SETUP_HI through the end of WAIT, and SHALL hold its last value in IDLE.
REQ-028 WAIT SHALL last T_WAIT_LONG cycles when the latched iRS=0 and the byte is 0x01, 0x02 or 0x03; otherwise it SHALL last T_WAIT cycles.
REQ-029 On leaving WAIT the state SHALL return to IDLE, and oDone=1 and oReady=1 SHALL be asserted in that first IDLE cycle.
REQ-030 The latency from the accept edge to oDone SHALL be 2*(T_SETUP+T_EN+T_HOLD)+T_GAP+Twait+1 cycles, where Twait is the WAIT length selected by REQ-028; this is 2081 cycles for the default parameters.
REQ-031 iValid may be held high across oDone; the next byte SHALL then be accepted in the same cycle oDone is high, with no dead cycle between bytes.
REQ-032 A single down-counter of at least 17 bits SHALL time all phases.
REQ-033 The counter SHALL load (phase length - 1) on entering a state and move to the next state at 0.
REQ-034 The counter SHALL never wrap.
REQ-035 Setting a phase parameter to 0 SHALL be treated as 1 cycle.

Reset
REQ-036 While Reset=0, the block SHALL hold state IDLE, counter 0, oLCD_Data=0, oLCD_Enabled=0, oLCD_RegisterSelect=0, oDone=0 and latched byte 0, with oReady=1 from the first cycle after release.
REQ-037 oLCD_ReadWrite SHALL be 0 and oLCD_StrataFlashControl SHALL be 1 at all times, including during reset.
REQ-038 A reset asserted mid-transfer, including during PULSE_*, SHALL drop E to 0 immediately (asynchronously), abandon the byte and emit no oDone.

Verification
REQ-039 Reset release, then iData=0x41, iRS=1 with a 1-cycle iValid -> oLCD_Data=4 around an E pulse of 12 cycles, then 1 around a second E pulse of 12 cycles, the rising edges of the two pulses 65 cycles apart, RS=1 throughout, oDone exactly 2081 cycles after accept.
REQ-040 iData=0x01, iRS=0 -> long wait selected, oDone 82081 cycles after accept, RS=0 throughout.
REQ-041 iData=0x28, iRS=0 -> short wait (0x28 is not in {0x01..0x03}), oDone at 2081 cycles.
REQ-042 iValid toggled randomly while busy -> no extra E pulses and no change to oLCD_Data; exactly one oDone per accepted byte.
REQ-043 iValid held high with three queued bytes in sequence -> each accepted on its predecessor's oDone cycle, giving 6 E pulses and 3 oDone pulses in total.
REQ-044 Reset pulled low during PULSE_LO -> E=0 in the same cycle with no oDone; a following byte 0x30 then transfers normally.
